// File: rtl/npc_ctrl_pkg.sv
// Shared definitions for the NPC sequencing controller: the state encoding
// and the PC source selector values seen by the PC mux.
package npc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] PC_SEL_NEXT = 2'd0;
    localparam logic [1:0] PC_SEL_TRAP = 2'd1;
    localparam logic [1:0] PC_SEL_MEPC = 2'd2;

endpackage

// File: rtl/npc_ctrl_watchdog.sv
// Bus-wait watchdog. Counts consecutive enabled cycles and flags expiry on
// the cycle where the count would reach TIMEOUT_CYCLES, unless the awaited
// response shows up in that same cycle.
module ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic valid,
    output logic expire
);

    // cnt holds the number of wait cycles already completed, so the
    // TIMEOUT_CYCLES-th cycle is the one where cnt equals TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt;

    assign expire = en & ~valid & (cnt == LIMIT);

    // Count wait cycles; clear has priority so a state change always restarts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle sequencing controller for the NPC core.
// Optional bus watchdog: define NPC_CTRL_TIMEOUT_EN to bound FETCH/MEM waits
// to TIMEOUT_CYCLES and raise bus_err (then halt) on expiry.
module npc_ctrl
    import npc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    input  logic        ifu_valid,
    output logic        ir_we,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        is_csr_op,
    input  logic        ecall_en,
    input  logic        ebreak_en,
    input  logic        mret_en,
    input  logic        illegal,
    output logic        lsu_req,
    output logic        lsu_wen,
    input  logic        lsu_valid,
    output logic        rf_we,
    output logic        csr_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap_en,
    output logic        halt,
    output logic        bus_err,
    output logic [31:0] instret
);

    if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_to_w_check
        $error("npc_ctrl: TO_W too narrow for TIMEOUT_CYCLES");
    end

    state_t state;
    logic   expire;

`ifdef NPC_CTRL_TIMEOUT_EN
    logic in_wait;
    logic wait_valid;

    assign in_wait    = (state == S_FETCH) || (state == S_MEM);
    assign wait_valid = (state == S_FETCH) ? ifu_valid : lsu_valid;

    ctrl_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (~in_wait | wait_valid | expire),
        .en     (in_wait),
        .valid  (wait_valid),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Sequencer state and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            instret <= '0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH: begin
                    if (ifu_valid)   state <= S_DECODE;
                    else if (expire) state <= S_HALT;
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (ebreak_en)                  state <= S_HALT;
                    else if (illegal || ecall_en)   state <= S_TRAP;
                    else if (mem_read || mem_write) state <= S_MEM;
                    else                            state <= S_WB;
                end
                S_MEM: begin
                    if (lsu_valid)   state <= S_WB;
                    else if (expire) state <= S_HALT;
                end
                S_WB: begin
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                S_TRAP:   state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Strobe decode from the current state; IDLE and HALT leave every strobe low.
    always_comb begin
        ifu_req = 1'b0;
        ir_we   = 1'b0;
        lsu_req = 1'b0;
        lsu_wen = 1'b0;
        rf_we   = 1'b0;
        csr_we  = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = PC_SEL_NEXT;
        trap_en = 1'b0;
        halt    = 1'b0;
        bus_err = expire;
        case (state)
            S_FETCH: begin
                ifu_req = 1'b1;
                ir_we   = ifu_valid;
            end
            S_MEM: begin
                lsu_req = 1'b1;
                lsu_wen = mem_write;
            end
            S_WB: begin
                pc_we  = 1'b1;
                rf_we  = reg_write & ~mem_write;
                csr_we = is_csr_op;
                pc_sel = mret_en ? PC_SEL_MEPC : PC_SEL_NEXT;
            end
            S_TRAP: begin
                trap_en = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = PC_SEL_TRAP;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_npc_ctrl.sv
// Self-checking bench for npc_ctrl. Every cycle an expected output record is
// queued when the inputs are driven and compared on the following falling edge.
module tb_npc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_valid = 1'b0, lsu_valid = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, is_csr_op = 1'b0;
    logic        ecall_en = 1'b0, ebreak_en = 1'b0, mret_en = 1'b0, illegal = 1'b0;
    logic        ifu_req, ir_we, lsu_req, lsu_wen, rf_we, csr_we, pc_we, trap_en, halt, bus_err;
    logic [1:0]  pc_sel;
    logic [31:0] instret;

    always #5 clk = ~clk;

    npc_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_valid(ifu_valid), .ir_we(ir_we),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .is_csr_op(is_csr_op),
        .ecall_en(ecall_en), .ebreak_en(ebreak_en), .mret_en(mret_en), .illegal(illegal),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_valid(lsu_valid), .rf_we(rf_we),
        .csr_we(csr_we), .pc_we(pc_we), .pc_sel(pc_sel), .trap_en(trap_en), .halt(halt),
        .bus_err(bus_err), .instret(instret)
    );

    typedef struct packed {
        logic        ifu_req, ir_we, lsu_req, lsu_wen, rf_we, csr_we, pc_we;
        logic [1:0]  pc_sel;
        logic        trap_en, halt, bus_err;
        logic [31:0] instret;
    } obs_t;

    // cls: 0 = WB, 1 = MEM then WB, 2 = TRAP, 3 = HALT
    typedef struct {
        string      name;
        logic       mr, mw, rw, csr, ec, eb, mret, ill;
        int         fd, md, cls;
        logic       e_wen, e_rf, e_csr;
        logic [1:0] e_sel;
    } instr_t;

    obs_t        exp_q[$];
    string       tag_q[$];
    int          n_cmp = 0, n_err = 0;
    logic [31:0] exp_ir = 32'd0;
    obs_t        mon_e, mon_a;
    string       mon_t;
    instr_t      prog[9];

    function automatic instr_t mk(input string nm, input logic mr, mw, rw, csr, ec, eb, mret, ill,
                                  input int fd, md, cls, input logic e_wen, e_rf, e_csr,
                                  input logic [1:0] e_sel);
        instr_t t;
        t.name = nm; t.mr = mr; t.mw = mw; t.rw = rw; t.csr = csr;
        t.ec = ec; t.eb = eb; t.mret = mret; t.ill = ill;
        t.fd = fd; t.md = md; t.cls = cls;
        t.e_wen = e_wen; t.e_rf = e_rf; t.e_csr = e_csr; t.e_sel = e_sel;
        return t;
    endfunction

    function automatic obs_t base();
        obs_t o = '0;
        o.instret = exp_ir;
        return o;
    endfunction

    task automatic cyc(input logic r, iv, lv, input obs_t e, input string tag);
        @(posedge clk);
        #1;
        rst = r; ifu_valid = iv; lsu_valid = lv;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic set_flags(input instr_t t);
        mem_read = t.mr; mem_write = t.mw; reg_write = t.rw; is_csr_op = t.csr;
        ecall_en = t.ec; ebreak_en = t.eb; mret_en = t.mret; illegal = t.ill;
    endtask

    // Reset asserted during a cycle whose outputs are `cur`, then one IDLE cycle.
    task automatic rst_pulse(input obs_t cur, input string tag);
        cyc(1'b1, 1'b0, 1'b0, cur, tag);
        exp_ir = 32'd0;
        cyc(1'b0, 1'b0, 1'b0, base(), {tag, " idle"});
    endtask

    task automatic run_instr(input instr_t t);
        obs_t e;
        for (int i = 0; i <= t.fd; i++) begin
            e = base(); e.ifu_req = 1'b1; e.ir_we = (i == t.fd);
            cyc(1'b0, (i == t.fd), 1'b0, e, {t.name, " fetch"});
            if (i == 0) set_flags(t);
        end
        cyc(1'b0, 1'b1, 1'b0, base(), {t.name, " decode"});
        cyc(1'b0, 1'b0, 1'b1, base(), {t.name, " exec"});
        if (t.cls == 1) begin
            for (int j = 0; j <= t.md; j++) begin
                e = base(); e.lsu_req = 1'b1; e.lsu_wen = t.e_wen;
                cyc(1'b0, 1'b0, (j == t.md), e, {t.name, " mem"});
            end
        end
        if (t.cls <= 1) begin
            e = base(); e.pc_we = 1'b1; e.rf_we = t.e_rf; e.csr_we = t.e_csr; e.pc_sel = t.e_sel;
            cyc(1'b0, 1'b1, 1'b1, e, {t.name, " wb"});
            exp_ir = exp_ir + 32'd1;
        end else if (t.cls == 2) begin
            e = base(); e.trap_en = 1'b1; e.pc_we = 1'b1; e.pc_sel = 2'd1;
            cyc(1'b0, 1'b0, 1'b0, e, {t.name, " trap"});
        end else begin
            for (int k = 0; k < 100; k++) begin
                e = base(); e.halt = 1'b1;
                cyc(1'b0, (k % 7 == 0), (k % 5 == 0), e, {t.name, " halt"});
            end
        end
    endtask

    // Scoreboard: pop the expectation queued for this cycle and compare.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            mon_a = {ifu_req, ir_we, lsu_req, lsu_wen, rf_we, csr_we, pc_we,
                     pc_sel, trap_en, halt, bus_err, instret};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL %s: got %h required %h (req,irwe,lreq,lwen,rfwe,csrwe,pcwe,sel,trap,halt,berr,instret)",
                         mon_t, mon_a, mon_e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        obs_t e;
        //                 name      mr mw rw cs ec eb mr il  fd md cls wen rf csr sel
        prog[0] = mk("add",     0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0,  1, 0, 2'd0);
        prog[1] = mk("load",    1, 0, 1, 0, 0, 0, 0, 0,  0, 2, 1,  0,  1, 0, 2'd0);
        prog[2] = mk("store",   0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 1,  1,  0, 0, 2'd0);
        prog[3] = mk("csrrw",   0, 0, 1, 1, 0, 0, 0, 0,  2, 0, 0,  0,  1, 1, 2'd0);
        prog[4] = mk("ecall",   0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 2,  0,  0, 0, 2'd0);
        prog[5] = mk("illegal", 1, 0, 1, 0, 0, 0, 0, 1,  1, 0, 2,  0,  0, 0, 2'd0);
        prog[6] = mk("mret",    0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0,  0, 0, 2'd2);
        prog[7] = mk("branch",  0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0,  0,  0, 0, 2'd0);
        prog[8] = mk("ebreak",  0, 0, 1, 0, 0, 1, 0, 1,  0, 0, 3,  0,  0, 0, 2'd0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        rst_pulse(base(), "reset");

        for (int n = 0; n < 9; n++) run_instr(prog[n]);

        // Leave HALT via reset, retire one, then reset in the middle of FETCH.
        e = base(); e.halt = 1'b1;
        rst_pulse(e, "halt rst");
        run_instr(prog[0]);
        e = base(); e.ifu_req = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, e, "midfetch f1");
        cyc(1'b0, 1'b0, 1'b0, e, "midfetch f2");
        rst_pulse(e, "midfetch rst");
        run_instr(prog[0]);

        // Reset in the middle of a load's MEM wait.
        e = base(); e.ifu_req = 1'b1; e.ir_we = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, e, "midmem fetch");
        set_flags(prog[1]);
        cyc(1'b0, 1'b0, 1'b0, base(), "midmem decode");
        cyc(1'b0, 1'b0, 1'b0, base(), "midmem exec");
        e = base(); e.lsu_req = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, e, "midmem m1");
        cyc(1'b0, 1'b0, 1'b0, e, "midmem m2");
        rst_pulse(e, "midmem rst");
        run_instr(prog[1]);

`ifdef NPC_CTRL_TIMEOUT_EN
        // FETCH timeout: bus_err on the 4th waiting cycle, then HALT.
        for (int i = 0; i < 4; i++) begin
            e = base(); e.ifu_req = 1'b1; e.bus_err = (i == 3);
            cyc(1'b0, 1'b0, 1'b0, e, "wd fetch");
        end
        for (int i = 0; i < 3; i++) begin
            e = base(); e.halt = 1'b1;
            cyc(1'b0, 1'b1, 1'b0, e, "wd halt");
        end
        rst_pulse(e, "wd halt rst");
        // Reset mid-FETCH, then a full 4-cycle wait must not expire (counter restarted, valid wins).
        e = base(); e.ifu_req = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, e, "wd midfetch f1");
        cyc(1'b0, 1'b0, 1'b0, e, "wd midfetch f2");
        rst_pulse(e, "wd midfetch rst");
        run_instr(prog[7]);
        // MEM timeout.
        e = base(); e.ifu_req = 1'b1; e.ir_we = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, e, "wd mem fetch");
        set_flags(prog[1]);
        cyc(1'b0, 1'b0, 1'b0, base(), "wd mem decode");
        cyc(1'b0, 1'b0, 1'b0, base(), "wd mem exec");
        for (int i = 0; i < 4; i++) begin
            e = base(); e.lsu_req = 1'b1; e.bus_err = (i == 3);
            cyc(1'b0, 1'b0, 1'b0, e, "wd mem");
        end
        e = base(); e.halt = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, e, "wd mem halt");
        cyc(1'b0, 1'b0, 1'b0, e, "wd mem halt");
`else
        // Without the watchdog a long fetch wait is unbounded and bus_err stays low.
        run_instr(mk("slowfetch", 0, 0, 1, 0, 0, 0, 0, 0, 12, 0, 0, 0, 1, 0, 2'd0));
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/npc_ctrl.md
# npc_ctrl

Multi-cycle sequencing controller for the NPC core. It drives instruction fetch, hands the latched instruction to the decoder, and consumes the decoder's control flags. It then sequences optional memory access and write-back, and gates every architectural write enable (IR, PC, register file, CSR). It also routes ECALL/illegal instructions to a trap step and freezes the core on EBREAK.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum wait for a bus response before an error is raised (used only with the watchdog).
- TO_W, 8: watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_req  out  1  instruction fetch request; held high until accepted.
- ifu_valid  in  1  fetch response; instruction is on the bus this cycle.
- ir_we  out  1  one-cycle pulse that latches the instruction register.
- mem_read, mem_write, reg_write, is_csr_op  in  1 each  decoder flags.
- ecall_en, ebreak_en, mret_en  in  1 each  decoder flags.
- illegal  in  1  decoder flag: unrecognised encoding.
- lsu_req  out  1  data memory request; held high until accepted.
- lsu_wen  out  1  store qualifier, valid while lsu_req is high.
- lsu_valid  in  1  data memory response.
- rf_we  out  1  register-file write strobe.
- csr_we  out  1  CSR write strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  2  PC source: 0 = next/branch from EXU, 1 = trap vector (mtvec), 2 = mepc.
- trap_en  out  1  one-cycle pulse that writes mepc/mcause.
- halt  out  1  sticky core-stopped flag.
- bus_err  out  1  one-cycle pulse on a watchdog expiry.
- instret  out  32  retired-instruction count; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT.
- IDLE: entered for exactly one cycle after rst deasserts; next state is FETCH.
- FETCH: ifu_req=1. When ifu_valid=1: pulse ir_we and go to DECODE.
- DECODE: one cycle; the decoder settles from the IR.
- EXEC: one cycle. Next state, in priority order:
  - ebreak_en → HALT
  - illegal or ecall_en → TRAP
  - mem_read or mem_write → MEM
  - otherwise → WB
- MEM: lsu_req=1 and lsu_wen=mem_write. When lsu_valid=1, go to WB.
- WB: one cycle. Outputs:
  - pc_we=1.
  - rf_we = reg_write & ~mem_write.
  - csr_we = is_csr_op.
  - pc_sel = 2 if mret_en, else 0.
  - instret increments.
  - Next state is FETCH.
- TRAP: one cycle with trap_en=1, pc_we=1, pc_sel=1; instret does not increment. Next state is FETCH.
- HALT: absorbing state; only rst leaves it. halt=1 and all strobes are 0.
- ifu_valid or lsu_valid arriving outside its own wait state is ignored.

## Timing
- Reset values: state=IDLE, instret=0, all outputs 0, watchdog counter 0.
- All strobes are Moore outputs decoded from the state register.
- Minimum latency, with the response arriving in the first wait cycle:
  - ALU/branch/jump/CSR instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Trap: 4 cycles.
- A response arriving in the same cycle as the request is accepted.
- rst asserted in any state, including mid-FETCH or mid-MEM, returns to IDLE at the next edge. The req output drops at that edge; the outstanding transaction is abandoned.

## Configuration
- NPC_CTRL_TIMEOUT_EN defined:
  - The watchdog counts consecutive cycles spent in FETCH or MEM and clears on every state change.
  - When the count reaches TIMEOUT_CYCLES with no valid in that cycle: pulse bus_err and go to HALT.
  - If valid arrives in the same cycle the limit is reached, valid wins.
- Not defined: waits in FETCH and MEM are unbounded, and bus_err is tied to 0.

## Structure
- Shared package npc_ctrl_pkg holds:
  - the state enum (3 bits);
  - the pc_sel encodings PC_SEL_NEXT=0, PC_SEL_TRAP=1, PC_SEL_MEPC=2.
- Sub-module ctrl_watchdog holds the TO_W-bit counter with clear/enable/expire; it is instantiated only under the macro.

## Test plan
- ADD with ifu_valid on the first FETCH cycle → rf_we high in cycle 4 after IDLE; pc_we=1, pc_sel=0; instret 0→1.
- Load with lsu_valid delayed 3 cycles → lsu_req high for 3 cycles with lsu_wen=0; rf_we one cycle later; total 7 cycles.
- Store → lsu_wen=1 throughout MEM; rf_we stays 0 in WB; instret increments.
- ECALL, then illegal encoding → each gives TRAP with trap_en=1, pc_sel=1 for one cycle; instret unchanged.
- MRET → WB with pc_sel=2. EBREAK → halt=1 and stays high for 100 cycles despite further ifu_valid pulses.
- Watchdog with TIMEOUT_CYCLES=4 and ifu_valid held low → bus_err pulse on the 4th FETCH cycle, then HALT. Repeat with rst asserted mid-FETCH → IDLE, then FETCH restarts with the counter at 0.
